// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD serial adder.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;
    localparam int BCD_CORR    = 6;

    function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] d);
        return d <= BCD_DIGIT_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder: binary add, then +6 correction when the sum exceeds 9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   ci,
    output logic [BCD_DIGIT_W-1:0] d,
    output logic                   co
);

    logic [BCD_DIGIT_W:0] s;

    always_comb begin
        s  = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, ci};
        d  = s[BCD_DIGIT_W-1:0];
        co = 1'b0;
        if (s > (BCD_DIGIT_W + 1)'(BCD_MAX)) begin
            // Wraps mod 16; for invalid input digits the result is meaningless by design.
            d  = s[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_CORR);
            co = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit packed-BCD adder that time-shares one digit adder, LSD first,
// with a start/busy/done handshake and a sticky invalid-digit flag.
module bcd_serial_adder_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS+3:0]   sum,
    output logic                  invalid,
    output state_e                dbg_state
);

    localparam int IDX_W = $clog2(DIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_e               state_q;
    logic [4*DIGITS-1:0]  a_q;
    logic [4*DIGITS-1:0]  b_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 carry_q;
    logic [4*DIGITS+3:0]  sum_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 inv_q;

    logic [3:0]           a_dig;
    logic [3:0]           b_dig;
    logic [3:0]           d_dig;
    logic                 co_d;

    assign a_dig = a_q[{idx_q, 2'b00} +: 4];
    assign b_dig = b_q[{idx_q, 2'b00} +: 4];

    bcd_digit_add u_digit_add (
        .a  (a_dig),
        .b  (b_dig),
        .ci (carry_q),
        .d  (d_dig),
        .co (co_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= 1'b0;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        inv_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= d_dig;
                    carry_q <= co_d;
                    inv_q   <= inv_q | ~is_bcd_digit(a_dig) | ~is_bcd_digit(b_dig);
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        sum_q[4*DIGITS +: 4] <= {3'b000, co_d};
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // done is registered here, so it is seen while the FSM is already back in IDLE.
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign invalid   = inv_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench: directed literal cases plus random traffic checked every cycle
// against a decimal-arithmetic reference model.
module tb_bcd_serial_adder_ctrl;
    import bcd_pkg::*;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int SW     = 4 * (DIGITS + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic [SW-1:0] sum;
    logic          invalid;
    state_e        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .invalid   (invalid),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [SW-1:0] int_to_bcd(input int v);
        logic [SW-1:0] r = '0;
        int t = v;
        for (int i = 0; i <= DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic has_invalid(input logic [W-1:0] v);
        logic bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++)
            r[4*i +: 4] = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Reference model: counts cycles since acceptance and produces the decimal sum at done.
    int            m_phase = 0;
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic          m_inv = 1'b0;
    logic          m_known = 1'b1;
    logic [SW-1:0] m_sum = '0;
    logic          p_inv;
    logic          p_known;
    logic [SW-1:0] p_sum;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_busy = 1'b0; m_done = 1'b0;
            m_inv = 1'b0; m_known = 1'b1; m_sum = '0;
        end else begin
            m_done = 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    p_sum   = int_to_bcd(bcd_to_int(a) + bcd_to_int(b));
                    p_inv   = has_invalid(a) | has_invalid(b);
                    p_known = !p_inv;
                    m_phase = 1;
                    m_busy  = 1'b1;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (m_phase == DIGITS + 1) begin
                m_done  = 1'b1;
                m_sum   = p_sum;
                m_inv   = p_inv;
                m_known = p_known;
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            if (m_phase == 0) begin
                if (m_known) check("sum", 32'(sum), 32'(m_sum));
                check("invalid", 32'(invalid), 32'(m_inv));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [SW-1:0] es, input logic ei,
                          input bit chk_sum, input bit immediate);
        int k;
        if (!immediate) @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'd5);
        if (chk_sum) check("sum_lit", 32'(sum), 32'(es));
        check("inv_lit", 32'(invalid), 32'(ei));
    endtask

    initial begin
        int k;
        int extra;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_inv", 32'(invalid), 32'd0);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h5678, 20'h06912, 1'b0, 1'b1, 1'b0);
        run_op(16'h9999, 16'h9999, 20'h19998, 1'b0, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 20'h00000, 1'b0, 1'b1, 1'b0);
        run_op(16'h0001, 16'h0009, 20'h00010, 1'b0, 1'b1, 1'b1);

        run_op(16'h00A1, 16'h0001, 20'h0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("inv_hold", 32'(invalid), 32'd1);
        run_op(16'h0002, 16'h0003, 20'h00005, 1'b0, 1'b1, 1'b0);

        // start re-asserted with new operands while running must be ignored.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(negedge clk);
        a = 16'h8888; b = 16'h1111;
        repeat (2) @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("run_ign_lat", 32'(k), 32'd3);
        check("run_ign_sum", 32'(sum), 32'h03333);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("extra_done", 32'(extra), 32'd0);

        // Mid-run asynchronous reset during digit 2.
        @(negedge clk);
        a = 16'h00A5; b = 16'h0005; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_pre", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_sum", 32'(sum), 32'd0);
        check("mrst_inv", 32'(invalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0005, 16'h0005, 20'h00010, 1'b0, 1'b1, 1'b0);

        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a = rand_operand();
            b = rand_operand();
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
